hitspy6_track_packer: RTL and testbench
=======================================

Name: hitspy6_track_packer

Overview:
- Downstream neighbour of the six-layer hit holding stage in the GigaFitter output path.
- Consumes the held hits for one track candidate together with the chi-square verdict.
- For each track that passes, captures the hits into shadow registers and emits a 7-word output packet on a HOLD-throttled word stream.
- Emits end-of-event words, counts accepted and rejected tracks, and flags verdicts dropped while busy.

Parameters:
HITBITS_SVX, 8, width of SVX-layer hits (layers 1-5)
HITBITS_XFT, 13, width of XFT-layer hit (layer 6)
CHIBITS, 11, width of chi-square value carried in trailer word
OUTBITS, 21, output word width
CNTBITS, 16, width of accepted/rejected track counters

Ports:
CLOCK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
hits1..hits5  in  HITBITS_SVX each  held SVX hits, layers 1-5
hits6  in  HITBITS_XFT  held XFT hit
HITMAP  in  5  layer-present map for layers 1-5, bit0 = layer 1
CHI_DV  in  1  one-cycle strobe: CHI_PASS, CHI_VAL, hits and HITMAP valid this cycle
CHI_PASS  in  1  track passed chi-square cut
CHI_VAL  in  CHIBITS  chi-square value
EVT_END  in  1  one-cycle end-of-event strobe
HOLD  in  1  downstream not ready
DOUT  out  OUTBITS  output word
DOUT_DV  out  1  DOUT valid
BUSY  out  1  registered; high whenever state != IDLE
OVERFLOW  out  1  sticky; CHI_DV with CHI_PASS=1 arrived while BUSY
NACC  out  CNTBITS  accepted-track counter, saturating
NREJ  out  CNTBITS  rejected-track counter, saturating

Behaviour:
- Reset (async, RESET_N=0): state IDLE. DOUT=0, DOUT_DV=0, BUSY=0, OVERFLOW=0, NACC=0, NREJ=0, shadow registers and ee_pending cleared. Reset mid-packet abandons the packet with no partial trailer.
- Word format:
  - bit20 EP: last word of track.
  - bit19 EE: end of event.
  - bits18:16: word index.
  - bit15: layer valid.
  - bits12:0: zero-extended hit.
  - Hit word index k=0..5 carries hits(k+1). Bit15 = HITMAP[k] for k<5; bit15 = 1 for k=5.
  - Trailer, index 6: EP=1, bits15:11=HITMAP, bits10:0=CHI_VAL.
  - EE word: index 7, EE=1, all other bits 0.
- Transfer rule:
  - A word transfers at a rising edge where DOUT_DV=1 and HOLD=0.
  - While HOLD=1, DOUT and DOUT_DV are held stable and the word counter is frozen.
- FSM states:
  - IDLE:
    - CHI_DV & CHI_PASS: capture hits, HITMAP and CHI_VAL into shadow regs; NACC++; go SEND with word 0 presented the next cycle (latency 1).
    - CHI_DV & !CHI_PASS: NREJ++; no output; stay IDLE.
    - Else EVT_END or ee_pending: present EE word; go EE.
  - SEND:
    - Counter 0..6 advances on each transfer.
    - After word 6 transfers: go EE if ee_pending or EVT_END that cycle; otherwise go IDLE with DOUT_DV=0.
    - Minimum packet is 7 cycles.
  - EE: on transfer, clear ee_pending, DOUT_DV=0, go IDLE.
- Simultaneous and boundary events:
  - EVT_END while not IDLE sets ee_pending. At most one pending EE; further strobes merge.
  - CHI_DV and EVT_END in the same IDLE cycle: the track packet goes first, then the EE word.
  - CHI_DV while BUSY: CHI_PASS=1 sets OVERFLOW and the track is dropped with no count change. CHI_PASS=0 still counts NREJ.
  - Counters saturate at all-ones; no wrap.
  - Shadow registers isolate the packet from upstream copy-register updates during SEND.

Decomposition:
- Shared package gf_out_pkg:
  - Field positions: EP_BIT=20, EE_BIT=19, IDX_MSB/LSB=18/16, LV_BIT=15.
  - Index constants: IDX_TRAILER=6, IDX_EE=7.
  - FSM state encoding: IDLE, SEND, EE.
- One sub-module gf_sat_counter (parameter width; inc, clear; saturating), instantiated for NACC and NREJ.

Test Plan:
1. Reset, then CHI_DV/PASS=1 with hits1..5=0x11..0x55, hits6=0x1ABC, HITMAP=5'b10101, CHI_VAL=0x123, HOLD=0 -> words 1 cycle later, in order:
   - Index 0 = 0x008011.
   - Index 5 = 0x059ABC.
   - Trailer = 0x16A923.
   - DOUT_DV high for exactly 7 cycles, BUSY drops the next cycle, NACC=1.
2. CHI_DV with CHI_PASS=0 -> no DOUT_DV, NREJ=1, BUSY stays 0.
3. Packet in flight, HOLD=1 for 4 cycles during word 3 -> DOUT stable at index 3 throughout, no word skipped or repeated, packet finishes 4 cycles late.
4. EVT_END during word 2 and again during word 4 -> a single EE word 0x0F0000 follows the trailer immediately.
5. Second CHI_DV/PASS=1 during SEND -> OVERFLOW=1 and stays set, NACC unchanged, current packet intact.
6. RESET_N low mid-packet at word 4 -> all outputs 0 immediately; next CHI_DV produces a clean packet starting at index 0.

Source files
------------

// File: rtl/gf_out_pkg.sv
// Shared field layout, state encoding and word builders for the GigaFitter output packer.
package gf_out_pkg;

  localparam int HITBITS_SVX = 8;
  localparam int HITBITS_XFT = 13;
  localparam int CHIBITS     = 11;
  localparam int OUTBITS     = 21;
  localparam int CNTBITS     = 16;

  localparam int EP_BIT  = 20;
  localparam int EE_BIT  = 19;
  localparam int IDX_MSB = 18;
  localparam int IDX_LSB = 16;
  localparam int LV_BIT  = 15;

  localparam logic [2:0] IDX_TRAILER = 3'd6;
  localparam logic [2:0] IDX_EE      = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    EE   = 2'd2
  } state_e;

  function automatic logic [OUTBITS-1:0] hit_word(input logic [2:0] idx, input logic lv,
                                                  input logic [HITBITS_XFT-1:0] hit);
    logic [OUTBITS-1:0] w;
    w = '0;
    w[IDX_MSB:IDX_LSB] = idx;
    w[LV_BIT] = lv;
    w[HITBITS_XFT-1:0] = hit;
    return w;
  endfunction

  function automatic logic [OUTBITS-1:0] trailer_word(input logic [4:0] map,
                                                      input logic [CHIBITS-1:0] chi);
    logic [OUTBITS-1:0] w;
    w = '0;
    w[EP_BIT] = 1'b1;
    w[IDX_MSB:IDX_LSB] = IDX_TRAILER;
    w[15:11] = map;
    w[CHIBITS-1:0] = chi;
    return w;
  endfunction

  function automatic logic [OUTBITS-1:0] ee_word();
    logic [OUTBITS-1:0] w;
    w = '0;
    w[EE_BIT] = 1'b1;
    w[IDX_MSB:IDX_LSB] = IDX_EE;
    return w;
  endfunction

endpackage

// File: rtl/gf_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module gf_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hitspy6_track_packer.sv
// Packs accepted six-layer tracks into 7-word HOLD-throttled packets and appends end-of-event words.
module hitspy6_track_packer
  import gf_out_pkg::*;
(
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic [HITBITS_SVX-1:0] hits1,
  input  logic [HITBITS_SVX-1:0] hits2,
  input  logic [HITBITS_SVX-1:0] hits3,
  input  logic [HITBITS_SVX-1:0] hits4,
  input  logic [HITBITS_SVX-1:0] hits5,
  input  logic [HITBITS_XFT-1:0] hits6,
  input  logic [4:0]             HITMAP,
  input  logic                   CHI_DV,
  input  logic                   CHI_PASS,
  input  logic [CHIBITS-1:0]     CHI_VAL,
  input  logic                   EVT_END,
  input  logic                   HOLD,
  output logic [OUTBITS-1:0]     DOUT,
  output logic                   DOUT_DV,
  output logic                   BUSY,
  output logic                   OVERFLOW,
  output logic [CNTBITS-1:0]     NACC,
  output logic [CNTBITS-1:0]     NREJ
);

  localparam int PADW = HITBITS_XFT - HITBITS_SVX;

  state_e                         state_q;
  logic [5:0][HITBITS_XFT-1:0]    sh_q;
  logic [4:0]                     map_q;
  logic [CHIBITS-1:0]             chi_q;
  logic [2:0]                     idx_q;
  logic [OUTBITS-1:0]             dout_q;
  logic                           dv_q;
  logic                           busy_q;
  logic                           ovf_q;
  logic                           ee_pend_q;

  logic                           xfer;
  logic                           acc_d;
  logic                           rej_d;
  logic [2:0]                     idx_d;
  logic [OUTBITS-1:0]             word_d;

  assign xfer  = dv_q & ~HOLD;
  assign acc_d = CHI_DV & CHI_PASS & (state_q == IDLE);
  assign rej_d = CHI_DV & ~CHI_PASS;

  // Next word of the packet, always built from the shadow copy so upstream updates cannot leak in.
  always_comb begin
    idx_d  = idx_q + 3'd1;
    word_d = '0;
    if (idx_d == IDX_TRAILER) begin
      word_d = trailer_word(map_q, chi_q);
    end else if (idx_d == 3'd5) begin
      word_d = hit_word(idx_d, 1'b1, sh_q[5]);
    end else begin
      word_d = hit_word(idx_d, map_q[idx_d], sh_q[idx_d]);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      map_q     <= '0;
      chi_q     <= '0;
      idx_q     <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ee_pend_q <= 1'b0;
    end else begin
      if (CHI_DV && CHI_PASS && (state_q != IDLE)) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (CHI_DV && CHI_PASS) begin
            sh_q   <= {hits6, {PADW{1'b0}}, hits5, {PADW{1'b0}}, hits4,
                       {PADW{1'b0}}, hits3, {PADW{1'b0}}, hits2, {PADW{1'b0}}, hits1};
            map_q  <= HITMAP;
            chi_q  <= CHI_VAL;
            idx_q  <= 3'd0;
            dout_q <= hit_word(3'd0, HITMAP[0], {{PADW{1'b0}}, hits1});
            dv_q   <= 1'b1;
            busy_q <= 1'b1;
            state_q <= SEND;
            if (EVT_END) ee_pend_q <= 1'b1;
          end else if (EVT_END || ee_pend_q) begin
            dout_q    <= ee_word();
            dv_q      <= 1'b1;
            busy_q    <= 1'b1;
            ee_pend_q <= 1'b1;
            state_q   <= EE;
          end
        end
        SEND: begin
          if (EVT_END) ee_pend_q <= 1'b1;
          if (xfer) begin
            if (idx_q == IDX_TRAILER) begin
              if (ee_pend_q || EVT_END) begin
                dout_q  <= ee_word();
                state_q <= EE;
              end else begin
                dout_q  <= '0;
                dv_q    <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              idx_q  <= idx_d;
              dout_q <= word_d;
            end
          end
        end
        EE: begin
          // Strobes arriving while the EE word waits merge into it.
          if (xfer) begin
            ee_pend_q <= 1'b0;
            dout_q    <= '0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  gf_sat_counter #(.WIDTH(CNTBITS)) u_nacc (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .clear_i(1'b0),
    .inc_i  (acc_d),
    .count_o(NACC)
  );

  gf_sat_counter #(.WIDTH(CNTBITS)) u_nrej (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .clear_i(1'b0),
    .inc_i  (rej_d),
    .count_o(NREJ)
  );

  assign DOUT     = dout_q;
  assign DOUT_DV  = dv_q;
  assign BUSY     = busy_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_hitspy6_track_packer.sv
// Directed bench for hitspy6_track_packer: packet content, HOLD throttling, EE merging, overflow, reset.
module tb_hitspy6_track_packer;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic [7:0]  hits1, hits2, hits3, hits4, hits5;
  logic [12:0] hits6;
  logic [4:0]  HITMAP;
  logic        CHI_DV, CHI_PASS;
  logic [10:0] CHI_VAL;
  logic        EVT_END, HOLD;
  logic [20:0] DOUT;
  logic        DOUT_DV, BUSY, OVERFLOW;
  logic [15:0] NACC, NREJ;

  int checks = 0;
  int failures = 0;

  logic [20:0] exp_w[7];
  logic [20:0] rec_w[16];
  int          rec_n;
  int          exp_nacc;

  always #5 CLOCK = ~CLOCK;

  hitspy6_track_packer dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .hits1(hits1), .hits2(hits2), .hits3(hits3), .hits4(hits4), .hits5(hits5), .hits6(hits6),
    .HITMAP(HITMAP), .CHI_DV(CHI_DV), .CHI_PASS(CHI_PASS), .CHI_VAL(CHI_VAL),
    .EVT_END(EVT_END), .HOLD(HOLD),
    .DOUT(DOUT), .DOUT_DV(DOUT_DV), .BUSY(BUSY), .OVERFLOW(OVERFLOW),
    .NACC(NACC), .NREJ(NREJ)
  );

  task automatic set_vec(input int sel);
    if (sel == 0) begin
      hits1 = 8'h11; hits2 = 8'h22; hits3 = 8'h33; hits4 = 8'h44; hits5 = 8'h55;
      hits6 = 13'h1ABC; HITMAP = 5'b10101; CHI_VAL = 11'h123;
      exp_w[0] = 21'h008011; exp_w[1] = 21'h010022; exp_w[2] = 21'h028033;
      exp_w[3] = 21'h030044; exp_w[4] = 21'h048055; exp_w[5] = 21'h059ABC;
      exp_w[6] = 21'h16A923;
    end else begin
      hits1 = 8'h01; hits2 = 8'h02; hits3 = 8'h03; hits4 = 8'h04; hits5 = 8'hFF;
      hits6 = 13'h0001; HITMAP = 5'b01010; CHI_VAL = 11'h7FF;
      exp_w[0] = 21'h000001; exp_w[1] = 21'h018002; exp_w[2] = 21'h020003;
      exp_w[3] = 21'h038004; exp_w[4] = 21'h0400FF; exp_w[5] = 21'h058001;
      exp_w[6] = 21'h1657FF;
    end
  endtask

  // Called at a negedge; returns at the negedge where word 0 should be visible.
  task automatic launch(input bit pass);
    CHI_DV = 1'b1; CHI_PASS = pass;
    @(negedge CLOCK);
    CHI_DV = 1'b0; CHI_PASS = 1'b0;
  endtask

  // Drives HOLD/EVT_END/CHI_DV against the word index on DOUT and records every transferred word.
  task automatic run_packet(input int hold_idx, input int hold_len, input int evt_mask,
                            input int ovf_idx, output int dv_cycles, output int unstable,
                            output bit timeout);
    int held;
    bit seen;
    int idx;
    logic [20:0] held_word;
    rec_n = 0; dv_cycles = 0; unstable = 0; held = 0; seen = 0; timeout = 1;
    held_word = '0;
    for (int c = 0; c < 40; c++) begin
      HOLD = 1'b0; EVT_END = 1'b0; CHI_DV = 1'b0; CHI_PASS = 1'b0;
      if (DOUT_DV) begin
        seen = 1; dv_cycles++;
        idx = int'(DOUT[18:16]);
        if (idx == hold_idx && held < hold_len) begin
          if (held > 0 && DOUT !== held_word) unstable++;
          held_word = DOUT;
          HOLD = 1'b1; held++;
        end
        if (evt_mask[idx]) EVT_END = 1'b1;
        if (idx == ovf_idx) begin
          CHI_DV = 1'b1; CHI_PASS = 1'b1;
          hits1 = 8'hEE; hits6 = 13'h0F0F; HITMAP = 5'b11111; CHI_VAL = 11'h000;
        end
        if (!HOLD && rec_n < 16) begin
          rec_w[rec_n] = DOUT; rec_n++;
        end
      end else if (seen) begin
        timeout = 0;
        break;
      end
      @(negedge CLOCK);
    end
    HOLD = 1'b0; EVT_END = 1'b0; CHI_DV = 1'b0; CHI_PASS = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLOCK);
    checks++; if (DOUT !== 21'h0) begin failures++; $display("FAIL reset_dout got=%h exp=000000", DOUT); end
    checks++; if (DOUT_DV !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", DOUT_DV); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
    checks++; if (NACC !== 16'd0 || NREJ !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", NACC, NREJ); end
    RESET_N = 1'b1;
    @(negedge CLOCK);
    exp_nacc = 0;
  endtask

  task automatic test_accept();
    int dvc, unst;
    bit to;
    set_vec(0);
    launch(1'b1);
    checks++; if (BUSY !== 1'b1 || DOUT_DV !== 1'b1) begin failures++; $display("FAIL accept_latency got=busy%b/dv%b exp=1/1", BUSY, DOUT_DV); end
    run_packet(-1, 0, 0, -1, dvc, unst, to);
    exp_nacc++;
    checks++; if (to) begin failures++; $display("FAIL accept_timeout got=1 exp=0"); end
    checks++; if (dvc !== 7 || rec_n !== 7) begin failures++; $display("FAIL accept_len got=%0d/%0d exp=7/7", dvc, rec_n); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (rec_w[i] !== exp_w[i]) begin failures++; $display("FAIL accept_word%0d got=%h exp=%h", i, rec_w[i], exp_w[i]); end
    end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL accept_busy_drop got=%b exp=0", BUSY); end
    checks++; if (NACC !== 16'(exp_nacc)) begin failures++; $display("FAIL accept_nacc got=%0d exp=%0d", NACC, exp_nacc); end
  endtask

  task automatic test_reject();
    int dv_seen = 0, busy_seen = 0;
    set_vec(1);
    launch(1'b0);
    for (int c = 0; c < 5; c++) begin
      if (DOUT_DV) dv_seen++;
      if (BUSY) busy_seen++;
      @(negedge CLOCK);
    end
    checks++; if (dv_seen !== 0) begin failures++; $display("FAIL reject_dv got=%0d exp=0", dv_seen); end
    checks++; if (busy_seen !== 0) begin failures++; $display("FAIL reject_busy got=%0d exp=0", busy_seen); end
    checks++; if (NREJ !== 16'd1) begin failures++; $display("FAIL reject_nrej got=%0d exp=1", NREJ); end
    checks++; if (NACC !== 16'(exp_nacc)) begin failures++; $display("FAIL reject_nacc got=%0d exp=%0d", NACC, exp_nacc); end
  endtask

  task automatic test_hold();
    int dvc, unst;
    bit to;
    set_vec(0);
    launch(1'b1);
    run_packet(3, 4, 0, -1, dvc, unst, to);
    exp_nacc++;
    checks++; if (to) begin failures++; $display("FAIL hold_timeout got=1 exp=0"); end
    checks++; if (dvc !== 11) begin failures++; $display("FAIL hold_dv_cycles got=%0d exp=11", dvc); end
    checks++; if (unst !== 0) begin failures++; $display("FAIL hold_stable got=%0d exp=0", unst); end
    checks++; if (rec_n !== 7) begin failures++; $display("FAIL hold_words got=%0d exp=7", rec_n); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (rec_w[i] !== exp_w[i]) begin failures++; $display("FAIL hold_word%0d got=%h exp=%h", i, rec_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_evt_end();
    int dvc, unst;
    bit to;
    int late_dv = 0;
    set_vec(1);
    launch(1'b1);
    run_packet(-1, 0, 32'h14, -1, dvc, unst, to);
    exp_nacc++;
    checks++; if (to) begin failures++; $display("FAIL ee_timeout got=1 exp=0"); end
    checks++; if (dvc !== 8 || rec_n !== 8) begin failures++; $display("FAIL ee_len got=%0d/%0d exp=8/8", dvc, rec_n); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (rec_w[i] !== exp_w[i]) begin failures++; $display("FAIL ee_word%0d got=%h exp=%h", i, rec_w[i], exp_w[i]); end
    end
    checks++; if (rec_w[7] !== 21'h0F0000) begin failures++; $display("FAIL ee_eeword got=%h exp=0f0000", rec_w[7]); end
    for (int c = 0; c < 4; c++) begin
      if (DOUT_DV) late_dv++;
      @(negedge CLOCK);
    end
    checks++; if (late_dv !== 0) begin failures++; $display("FAIL ee_single got=%0d exp=0", late_dv); end
  endtask

  task automatic test_overflow();
    int dvc, unst;
    bit to;
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b exp=0", OVERFLOW); end
    set_vec(0);
    launch(1'b1);
    run_packet(-1, 0, 0, 2, dvc, unst, to);
    exp_nacc++;
    checks++; if (to || rec_n !== 7) begin failures++; $display("FAIL ovf_len got=%0d exp=7", rec_n); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (rec_w[i] !== exp_w[i]) begin failures++; $display("FAIL ovf_word%0d got=%h exp=%h", i, rec_w[i], exp_w[i]); end
    end
    checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", OVERFLOW); end
    checks++; if (NACC !== 16'(exp_nacc)) begin failures++; $display("FAIL ovf_nacc got=%0d exp=%0d", NACC, exp_nacc); end
    repeat (3) @(negedge CLOCK);
    checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", OVERFLOW); end
  endtask

  task automatic test_reset_mid();
    int dvc, unst;
    bit to;
    bit hit4 = 0;
    set_vec(0);
    launch(1'b1);
    for (int c = 0; c < 10; c++) begin
      if (DOUT_DV && DOUT[18:16] == 3'd4) begin hit4 = 1; break; end
      @(negedge CLOCK);
    end
    checks++; if (!hit4) begin failures++; $display("FAIL rstmid_reach got=0 exp=1"); end
    RESET_N = 1'b0;
    #1;
    checks++; if (DOUT !== 21'h0 || DOUT_DV !== 1'b0 || BUSY !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%h/%b/%b exp=000000/0/0", DOUT, DOUT_DV, BUSY);
    end
    checks++; if (OVERFLOW !== 1'b0 || NACC !== 16'd0 || NREJ !== 16'd0) begin
      failures++; $display("FAIL rstmid_state got=%b/%0d/%0d exp=0/0/0", OVERFLOW, NACC, NREJ);
    end
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(negedge CLOCK);
    set_vec(1);
    launch(1'b1);
    run_packet(-1, 0, 0, -1, dvc, unst, to);
    checks++; if (to || rec_n !== 7) begin failures++; $display("FAIL rstmid_len got=%0d exp=7", rec_n); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (rec_w[i] !== exp_w[i]) begin failures++; $display("FAIL rstmid_word%0d got=%h exp=%h", i, rec_w[i], exp_w[i]); end
    end
    checks++; if (NACC !== 16'd1) begin failures++; $display("FAIL rstmid_nacc got=%0d exp=1", NACC); end
  endtask

  initial begin
    RESET_N = 1'b0; CHI_DV = 1'b0; CHI_PASS = 1'b0; EVT_END = 1'b0; HOLD = 1'b0;
    set_vec(0);
    @(negedge CLOCK);
    test_reset();
    test_accept();
    test_reject();
    test_hold();
    test_evt_end();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
